mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath.
It sequences each instruction through fetch, decode, execute, memory and writeback steps.
It drives every datapath 2:1 and 4:1 mux select (IorD, ALUSrcA/B, MemtoReg, RegDst, PCSource) and every write enable.
It sits beside the datapath and receives only the IR opcode field.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/mips_ctrl_if.sv | 38 +++
 rtl/mips_ctrl_decode.sv | 78 +++++++
 rtl/mips_multicycle_ctrl.sv | 77 +++++++
 tb/tb_mips_multicycle_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM; MIPS_CTRL_JUMP_EN adds the JUMP state.
// Pure definitions: no logic, no latency, no backpressure.
package mips_ctrl_pkg;

  localparam int OP_W = 6;
  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_word_t;

endpackage

// File: rtl/mips_ctrl_if.sv
// Control bundle between the FSM (master) and the datapath (slave).
// Opcode flows in, selects/strobes flow out; no handshake.
interface mips_ctrl_if;
  import mips_ctrl_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            pc_write;
  logic            pc_write_cond;
  logic            i_or_d;
  logic            mem_read;
  logic            mem_write;
  logic            ir_write;
  logic            mem_to_reg;
  logic            reg_dst;
  logic            reg_write;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      alu_op;
  logic [1:0]      pc_source;
  logic            instr_done;
  logic            illegal_op;
  logic [ST_W-1:0] state;

  modport master (
    input  opcode,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control word decoder (Moore outputs, zero latency, no backpressure).
// JUMP state decode exists only with MIPS_CTRL_JUMP_EN; unused codes decode to all-zero.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.mem_read  = 1'b1;
        cw_o.ir_write  = 1'b1;
        cw_o.pc_write  = 1'b1;
        cw_o.alu_src_b = SRCB_FOUR;
        cw_o.alu_op    = ALU_ADD;
        cw_o.pc_source = PCSRC_ALU;
      end
      // Branch target computed speculatively so BRANCH can use ALUOut.
      S_DECODE: begin
        cw_o.alu_src_b = SRCB_IMM_SH2;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        cw_o.mem_read = 1'b1;
        cw_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.mem_to_reg = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        cw_o.mem_write  = 1'b1;
        cw_o.i_or_d     = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      S_EXEC_R: begin
        cw_o.alu_src_a = 1'b1;
        cw_o.alu_src_b = SRCB_B;
        cw_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.reg_dst    = 1'b1;
        cw_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alu_src_a     = 1'b1;
        cw_o.alu_src_b     = SRCB_B;
        cw_o.alu_op        = ALU_SUB;
        cw_o.pc_write_cond = 1'b1;
        cw_o.pc_source     = PCSRC_ALUOUT;
        cw_o.instr_done    = 1'b1;
      end
      S_ADDI_WB: begin
        cw_o.reg_write  = 1'b1;
        cw_o.instr_done = 1'b1;
      end
`ifdef MIPS_CTRL_JUMP_EN
      S_JUMP: begin
        cw_o.pc_write   = 1'b1;
        cw_o.pc_source  = PCSRC_JUMP;
        cw_o.instr_done = 1'b1;
      end
`endif
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, next-state, sticky illegal_op; outputs Moore.
// Latency lw 5 / sw,R,addi 4 / beq,j 3 cycles; no backpressure. MIPS_CTRL_JUMP_EN enables j.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mips_ctrl_if.master       ctrl_if
);

  state_t     state_q;
  logic       illegal_q;
  ctrl_word_t cw;
  ctrl_word_t cw_g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          case (ctrl_if.opcode)
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_RTYPE:     state_q <= S_EXEC_R;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_ADDI:      state_q <= S_ADDI_EXEC;
`ifdef MIPS_CTRL_JUMP_EN
            OP_J:         state_q <= S_JUMP;
`endif
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // Opcode is resampled here; anything other than lw/sw abandons the access.
        S_MEM_ADDR: begin
          if (ctrl_if.opcode == OP_LW)      state_q <= S_MEM_READ;
          else if (ctrl_if.opcode == OP_SW) state_q <= S_MEM_WRITE;
          else                              state_q <= S_FETCH;
        end
        S_MEM_READ:  state_q <= S_MEM_WB;
        S_EXEC_R:    state_q <= S_R_WB;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state_i (state_q),
    .cw_o    (cw)
  );

  // FETCH decodes to active strobes, so reset must mask them combinationally.
  assign cw_g = rst ? '0 : cw;

  assign ctrl_if.pc_write      = cw_g.pc_write;
  assign ctrl_if.pc_write_cond = cw_g.pc_write_cond;
  assign ctrl_if.i_or_d        = cw_g.i_or_d;
  assign ctrl_if.mem_read      = cw_g.mem_read;
  assign ctrl_if.mem_write     = cw_g.mem_write;
  assign ctrl_if.ir_write      = cw_g.ir_write;
  assign ctrl_if.mem_to_reg    = cw_g.mem_to_reg;
  assign ctrl_if.reg_dst       = cw_g.reg_dst;
  assign ctrl_if.reg_write     = cw_g.reg_write;
  assign ctrl_if.alu_src_a     = cw_g.alu_src_a;
  assign ctrl_if.alu_src_b     = cw_g.alu_src_b;
  assign ctrl_if.alu_op        = cw_g.alu_op;
  assign ctrl_if.pc_source     = cw_g.pc_source;
  assign ctrl_if.instr_done    = cw_g.instr_done;
  assign ctrl_if.illegal_op    = illegal_q;
  assign ctrl_if.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: table of instruction vectors plus reset/resample corner cases.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  mips_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      op;
    int              n;
    logic [5:0][3:0] seq;
    int              rw;
    int              done;
    logic            ill;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [16:0] mk(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw,
                                     asa, input logic [1:0] asb, aop, pcs, input logic done);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, done};
  endfunction

  // Expected control word per state, written straight from the state table.
  function automatic logic [16:0] exp_cw(input logic [3:0] s);
    case (s)
      4'd0:  return mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
      4'd1:  return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
      4'd2:  return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      4'd3:  return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
      4'd4:  return mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1);
      4'd5:  return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1);
      4'd6:  return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
      4'd7:  return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1);
      4'd8:  return mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1);
`ifdef MIPS_CTRL_JUMP_EN
      4'd9:  return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1);
`endif
      4'd10: return mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
      4'd11: return mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1);
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [16:0] obs();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done};
  endfunction

  function automatic logic [5:0][3:0] sq(input int a, b, c, d, e);
    logic [5:0][3:0] r;
    r    = '0;
    r[0] = 4'(a);
    r[1] = 4'(b);
    r[2] = 4'(c);
    r[3] = 4'(d);
    r[4] = 4'(e);
    return r;
  endfunction

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rw_cnt;
    int done_cnt;
    rw_cnt   = 0;
    done_cnt = 0;
    bus.opcode = v.op;
    for (int i = 0; i < v.n; i++) begin
      check("state", idx * 10 + i, 32'(bus.state), 32'(v.seq[i]));
      check("ctrl", idx * 10 + i, 32'(obs()), 32'(exp_cw(v.seq[i])));
      rw_cnt   += int'(bus.reg_write);
      done_cnt += int'(bus.instr_done);
      step();
    end
    check("return_to_fetch", idx, 32'(bus.state), 32'd0);
    check("reg_write_pulses", idx, 32'(rw_cnt), 32'(v.rw));
    check("instr_done_pulses", idx, 32'(done_cnt), 32'(v.done));
    check("illegal_op", idx, 32'(bus.illegal_op), 32'(v.ill));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{6'b100011, 5, sq(0, 1, 2, 3, 4), 1, 1, 1'b0};
    vecs[1] = '{6'b101011, 4, sq(0, 1, 2, 5, 0), 0, 1, 1'b0};
    vecs[2] = '{6'b000100, 3, sq(0, 1, 8, 0, 0), 0, 1, 1'b0};
    vecs[3] = '{6'b001000, 4, sq(0, 1, 10, 11, 0), 1, 1, 1'b0};
    vecs[4] = '{6'b000000, 4, sq(0, 1, 6, 7, 0), 1, 1, 1'b0};
`ifdef MIPS_CTRL_JUMP_EN
    vecs[5] = '{6'b000010, 3, sq(0, 1, 9, 0, 0), 0, 1, 1'b0};
`else
    vecs[5] = '{6'b000010, 2, sq(0, 1, 0, 0, 0), 0, 0, 1'b1};
`endif
    vecs[6] = '{6'b111111, 2, sq(0, 1, 0, 0, 0), 0, 0, 1'b1};
    vecs[7] = '{6'b000000, 4, sq(0, 1, 6, 7, 0), 1, 1, 1'b1};

    // Reset held three cycles: FETCH state but every output masked.
    rst        = 1'b1;
    bus.opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_state", i, 32'(bus.state), 32'd0);
      check("reset_outputs", i, 32'(obs()), 32'd0);
      check("reset_illegal", i, 32'(bus.illegal_op), 32'd0);
    end
    rst = 1'b0;
    #1;

    for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

    // Opcode changes outside DECODE/MEM_ADDR are ignored.
    bus.opcode = 6'b100011;
    step(); step(); step();
    check("hold_state3", 0, 32'(bus.state), 32'd3);
    bus.opcode = 6'b000000;
    step();
    check("hold_state4", 0, 32'(bus.state), 32'd4);
    check("hold_reg_write", 0, 32'(bus.reg_write), 32'd1);
    step();
    check("hold_fetch", 0, 32'(bus.state), 32'd0);

    // Opcode is resampled in MEM_ADDR: lw at DECODE, sw at MEM_ADDR -> store path.
    bus.opcode = 6'b100011;
    step(); step();
    check("resample_state2", 0, 32'(bus.state), 32'd2);
    bus.opcode = 6'b101011;
    step();
    check("resample_state5", 0, 32'(bus.state), 32'd5);
    check("resample_mem_write", 0, 32'(bus.mem_write), 32'd1);
    step();
    check("resample_fetch", 0, 32'(bus.state), 32'd0);

    // Asynchronous reset during MEM_READ of a lw: no writeback, illegal_op cleared.
    bus.opcode = 6'b100011;
    step(); step(); step();
    check("mid_rst_pre", 0, 32'(bus.state), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 0, 32'(bus.state), 32'd0);
    check("mid_rst_outputs", 0, 32'(obs()), 32'd0);
    check("mid_rst_illegal", 0, 32'(bus.illegal_op), 32'd0);
    step();
    check("mid_rst_hold_state", 0, 32'(bus.state), 32'd0);
    check("mid_rst_reg_write", 0, 32'(bus.reg_write), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_fetch", 0, 32'(obs()), 32'(exp_cw(4'd0)));
    step();
    check("post_rst_decode", 0, 32'(bus.state), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
